atmos_light_ctrl: RTL and testbench

Frame-level controller that sequences atmospheric-light (A) updates for the dehaze pipeline. It sits after the per-frame A estimator and in front of the transmission/recovery stages. It watches the frame vsync, accepts the one-cycle estimate pulse delivered after each frame end, smooths and clamps the estimate, and commits the new A only at the next frame start, so A stays constant across every frame.

---
 rtl/atmos_light_ctrl.sv | 178 +++++++++++++++++
 tb/tb_atmos_light_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/atmos_light_ctrl.sv
// Frame-level atmospheric-light (A) sequencer: accepts, smooths, clamps and commits A at frame start.
// Build option: define ATMOS_IIR_EN for IIR smoothing; otherwise each estimate loads directly.
module atmos_light_ctrl #(
  parameter int unsigned A_DEFAULT    = 230,
  parameter int unsigned A_MIN        = 100,
  parameter int unsigned A_MAX        = 255,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned EST_WAIT     = 16,
  parameter int unsigned MISS_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        a_in_valid,
  input  logic [7:0]  a_in,
  input  logic        a_update_en,
  input  logic        a_force_en,
  input  logic [7:0]  a_force_val,
  output logic [7:0]  A_out,
  output logic        A_out_valid,
  output logic [15:0] frame_cnt,
  output logic        stale
);

`ifdef ATMOS_IIR_EN
  localparam int unsigned Shift = SMOOTH_SHIFT;
`else
  // A zero shift makes the filter output equal the raw estimate.
  localparam int unsigned Shift = 0 * SMOOTH_SHIFT;
`endif

  localparam logic signed [9:0] MinS     = 10'(A_MIN);
  localparam logic signed [9:0] MaxS     = 10'(A_MAX);
  localparam logic [4:0]        WaitLast = 5'(EST_WAIT - 1);
  localparam logic [3:0]        MissLim  = 4'(MISS_LIMIT);

  typedef enum logic [2:0] {StIdle, StInFrame, StWaitEst, StUpdate, StWaitFrame} state_e;

  state_e      state_q, state_d;
  logic        vsync_d1_q;
  logic [7:0]  a_filt_q, a_filt_d;
  logic        first_q, first_d;
  logic [7:0]  pend_q, pend_d;
  logic [4:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic        stale_q, stale_d;
  logic [7:0]  a_lat_q, a_lat_d;
  logic        rise_pend_q, rise_pend_d;
  logic [7:0]  a_out_q, a_out_d;
  logic        a_out_valid_q, a_out_valid_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic              rise, fall, miss;
  logic signed [8:0] diff, step;
  logic signed [9:0] sum;
  logic [7:0]        filt_new;

  function automatic logic [7:0] clamp(input logic signed [9:0] x);
    logic signed [9:0] y;
    y = x;
    if (x < MinS) y = MinS;
    if (x > MaxS) y = MaxS;
    return y[7:0];
  endfunction

  assign rise = !vsync_d1_q && per_frame_vsync;
  assign fall = vsync_d1_q && !per_frame_vsync;

  // Filter datapath: 9-bit signed error, 10-bit signed accumulate.
  always_comb begin
    diff     = $signed({1'b0, a_lat_q}) - $signed({1'b0, a_filt_q});
    step     = diff >>> Shift;
    sum      = $signed({2'b00, a_filt_q}) + $signed({step[8], step});
    filt_new = first_q ? clamp($signed({2'b00, a_lat_q})) : clamp(sum);
  end

  always_comb begin
    state_d       = state_q;
    a_filt_d      = a_filt_q;
    first_d       = first_q;
    pend_d        = pend_q;
    wait_cnt_d    = wait_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    stale_d       = stale_q;
    a_lat_d       = a_lat_q;
    rise_pend_d   = rise_pend_q;
    a_out_d       = a_out_q;
    a_out_valid_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    miss          = 1'b0;

    // Frame start is honoured in every state, always committing the pend held before this edge.
    if (rise) begin
      frame_cnt_d   = frame_cnt_q + 16'd1;
      a_out_d       = a_force_en ? a_force_val : pend_q;
      a_out_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: if (rise) state_d = StInFrame;
      StInFrame: begin
        if (fall) begin
          state_d    = StWaitEst;
          wait_cnt_d = '0;
        end
      end
      StWaitEst: begin
        if (a_in_valid && a_update_en) begin
          state_d     = StUpdate;
          a_lat_d     = a_in;
          rise_pend_d = rise;
        end else if (rise) begin
          miss    = a_update_en;
          state_d = StInFrame;
        end else if (wait_cnt_q == WaitLast) begin
          miss    = a_update_en;
          state_d = StWaitFrame;
        end else begin
          wait_cnt_d = wait_cnt_q + 5'd1;
        end
      end
      StUpdate: begin
        a_filt_d    = filt_new;
        pend_d      = filt_new;
        first_d     = 1'b0;
        miss_cnt_d  = '0;
        stale_d     = 1'b0;
        rise_pend_d = 1'b0;
        state_d     = (rise_pend_q || rise) ? StInFrame : StWaitFrame;
      end
      StWaitFrame: if (rise) state_d = StInFrame;
      default: state_d = StIdle;
    endcase

    if (miss) begin
      if (miss_cnt_q != 4'hF) miss_cnt_d = miss_cnt_q + 4'd1;
      if (miss_cnt_d >= MissLim) stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      vsync_d1_q    <= 1'b0;
      a_filt_q      <= 8'(A_DEFAULT);
      first_q       <= 1'b1;
      pend_q        <= 8'(A_DEFAULT);
      wait_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      stale_q       <= 1'b0;
      a_lat_q       <= '0;
      rise_pend_q   <= 1'b0;
      a_out_q       <= 8'(A_DEFAULT);
      a_out_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      vsync_d1_q    <= per_frame_vsync;
      a_filt_q      <= a_filt_d;
      first_q       <= first_d;
      pend_q        <= pend_d;
      wait_cnt_q    <= wait_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      stale_q       <= stale_d;
      a_lat_q       <= a_lat_d;
      rise_pend_q   <= rise_pend_d;
      a_out_q       <= a_out_d;
      a_out_valid_q <= a_out_valid_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign A_out       = a_out_q;
  assign A_out_valid = a_out_valid_q;
  assign frame_cnt   = frame_cnt_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_atmos_light_ctrl.sv
// Directed self-checking bench for atmos_light_ctrl; expected A values follow the ATMOS_IIR_EN build.
module tb_atmos_light_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        a_in_valid;
  logic [7:0]  a_in;
  logic        a_update_en;
  logic        a_force_en;
  logic [7:0]  a_force_val;
  logic [7:0]  A_out;
  logic        A_out_valid;
  logic [15:0] frame_cnt;
  logic        stale;

  int n_pass = 0;
  int n_total = 0;

`ifdef ATMOS_IIR_EN
  localparam logic [7:0] E1 = 8'd180, E2 = 8'd147, E3 = 8'd160, E4 = 8'd147;
`else
  localparam logic [7:0] E1 = 8'd120, E2 = 8'd100, E3 = 8'd200, E4 = 8'd110;
`endif

  atmos_light_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .per_frame_vsync (vsync),
    .a_in_valid      (a_in_valid),
    .a_in            (a_in),
    .a_update_en     (a_update_en),
    .a_force_en      (a_force_en),
    .a_force_val     (a_force_val),
    .A_out           (A_out),
    .A_out_valid     (A_out_valid),
    .frame_cnt       (frame_cnt),
    .stale           (stale)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  // Raise vsync and check the frame-start commit, then the end of the valid pulse.
  task automatic rise_and_check(input string tag, input logic [7:0] exp_a,
                                input logic [15:0] exp_cnt, input logic exp_stale);
    vsync = 1'b1;
    tick(1);
    check({tag, "_valid"}, 32'(A_out_valid), 32'd1);
    check({tag, "_A"}, 32'(A_out), 32'(exp_a));
    check({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    check({tag, "_stale"}, 32'(stale), 32'(exp_stale));
    tick(1);
    check({tag, "_pulse"}, 32'(A_out_valid), 32'd0);
  endtask

  // Finish the frame, optionally deliver an estimate, then idle low_len cycles before the next rise.
  task automatic rest(input logic send, input logic [7:0] val, input int low_len);
    tick(2);
    vsync = 1'b0;
    tick(3);
    if (send) begin
      a_in_valid = 1'b1;
      a_in       = val;
      tick(1);
      a_in_valid = 1'b0;
    end
    tick(low_len);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; a_in_valid = 1'b0; a_in = '0;
    a_update_en = 1'b1; a_force_en = 1'b0; a_force_val = '0;
    tick(2);
    check("rst_A", 32'(A_out), 32'd230);
    check("rst_valid", 32'(A_out_valid), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_stale", 32'(stale), 32'd0);
    rst = 1'b0;
    tick(2);

    rise_and_check("f1", 8'd230, 16'd1, 1'b0);
    rest(1'b1, 8'd200, 3);
    rise_and_check("f2", 8'd200, 16'd2, 1'b0);
    rest(1'b1, 8'd120, 3);
    rise_and_check("f3", E1, 16'd3, 1'b0);
    rest(1'b1, 8'd50, 3);
    rise_and_check("f4", E2, 16'd4, 1'b0);

    // Miss 1 (early rise) with a forced commit.
    rest(1'b0, 8'd0, 2);
    a_force_en = 1'b1; a_force_val = 8'd20;
    rise_and_check("force", 8'd20, 16'd5, 1'b0);
    a_force_en = 1'b0;
    rest(1'b0, 8'd0, 20);
    rise_and_check("miss2", E2, 16'd6, 1'b0);
    rest(1'b0, 8'd0, 2);
    rise_and_check("miss3", E2, 16'd7, 1'b0);
    rest(1'b0, 8'd0, 20);
    rise_and_check("miss4", E2, 16'd8, 1'b1);
    rest(1'b1, 8'd200, 3);
    check("stale_clr", 32'(stale), 32'd0);
    rise_and_check("f9", E3, 16'd9, 1'b0);

    // Updates disabled: estimates ignored, timeouts not counted as misses.
    a_update_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rest(1'b1, 8'd90, 20);
      rise_and_check("frozen", E3, 16'(10 + i), 1'b0);
    end
    a_update_en = 1'b1;

    // Estimate and rise on the same cycle: old value now, new value next frame.
    tick(1);
    vsync = 1'b0;
    tick(4);
    vsync = 1'b1; a_in_valid = 1'b1; a_in = 8'd110;
    tick(1);
    a_in_valid = 1'b0;
    check("coll_A", 32'(A_out), 32'(E3));
    check("coll_cnt", 32'(frame_cnt), 32'd14);
    tick(1);
    check("coll_pulse", 32'(A_out_valid), 32'd0);
    rest(1'b0, 8'd0, 20);
    rise_and_check("coll_next", E4, 16'd15, 1'b0);

    // Reset while an estimate is arriving in WAIT_EST.
    rest(1'b0, 8'd0, 0);
    a_in_valid = 1'b1; a_in = 8'd240; rst = 1'b1;
    tick(1);
    a_in_valid = 1'b0;
    check("mrst_A", 32'(A_out), 32'd230);
    check("mrst_cnt", 32'(frame_cnt), 32'd0);
    check("mrst_valid", 32'(A_out_valid), 32'd0);
    check("mrst_stale", 32'(stale), 32'd0);
    rst = 1'b0;
    tick(2);
    rise_and_check("mrst_f1", 8'd230, 16'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
